// File: rtl/axi_lite_ahb_bridge_pkg.sv
// axi_lite_ahb_bridge_pkg: shared FSM state, AHB encodings and AXI response codes for the bridge
package axi_lite_ahb_bridge_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WDATA,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_RRESP
  } state_e;
  localparam logic [1:0] HTRANS_IDLE     = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
  localparam logic [2:0] HSIZE_BYTE      = 3'b000;
  localparam logic [2:0] HSIZE_HALF      = 3'b001;
  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_NC   = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_lite_ahb_bridge_ahb_strb_decode.sv
// ahb_strb_decode: maps a 4-bit AXI write strobe to AHB hsize and the byte offset within the word
// Ports: wstrb_i (AXI strobes) -> hsize_o (AHB size), addr_lsb_o (haddr[1:0]), illegal_o (strobe has no AHB equivalent)
module ahb_strb_decode
  import axi_lite_ahb_bridge_pkg::*;
(
  input  logic [3:0] wstrb_i,
  output logic [2:0] hsize_o,
  output logic [1:0] addr_lsb_o,
  output logic       illegal_o
);
  logic word, half, byte_sel;
  always_comb begin
    word       = wstrb_i == 4'b1111;
    half       = wstrb_i == 4'b0011 || wstrb_i == 4'b1100;
    byte_sel   = wstrb_i == 4'b0001 || wstrb_i == 4'b0010 || wstrb_i == 4'b0100 || wstrb_i == 4'b1000;
    hsize_o    = word ? HSIZE_WORD : half ? HSIZE_HALF : HSIZE_BYTE;
    addr_lsb_o = wstrb_i == 4'b1100 ? 2'd2 :
                 wstrb_i == 4'b0010 ? 2'd1 :
                 wstrb_i == 4'b0100 ? 2'd2 :
                 wstrb_i == 4'b1000 ? 2'd3 : 2'd0;
    illegal_o  = !(word || half || byte_sel);
  end
endmodule

// File: rtl/axi_lite_ahb_bridge.sv
// axi_lite_ahb_bridge: AXI4-Lite slave to AHB-Lite master, one single transfer outstanding, round-robin read/write
// Ports: clk, reset (async active-low); AXI aw*/w*/b* write channels and ar*/r* read channels (_i in, _o out);
//        AHB master haddr/htrans/hwrite/hsize/hburst/hprot/hwdata out, hrdata/hready/hresp in.
module axi_lite_ahb_bridge
  import axi_lite_ahb_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        wstrb_i,
  output logic              bvalid_o,
  input  logic              bready_i,
  output logic [1:0]        bresp_o,
  input  logic              arvalid_i,
  output logic              arready_o,
  input  logic [ADDR_W-1:0] araddr_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rresp_o,
  output logic [ADDR_W-1:0] haddr_o,
  output logic [1:0]        htrans_o,
  output logic              hwrite_o,
  output logic [2:0]        hsize_o,
  output logic [2:0]        hburst_o,
  output logic [3:0]        hprot_o,
  output logic [DATA_W-1:0] hwdata_o,
  input  logic [DATA_W-1:0] hrdata_i,
  input  logic              hready_i,
  input  logic              hresp_i
);
  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d, rdata_q, rdata_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d, dec_hsize;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d, dec_lsb;
  logic              dec_illegal, grant_w, grant_r;
  ahb_strb_decode u_dec (
    .wstrb_i   (wstrb_i),
    .hsize_o   (dec_hsize),
    .addr_lsb_o(dec_lsb),
    .illegal_o (dec_illegal)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rr_q     <= 1'b1;
      haddr_q  <= '0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      bresp_q  <= AXI_RESP_OKAY;
      rresp_q  <= AXI_RESP_OKAY;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      bresp_q  <= bresp_d;
      rresp_q  <= rresp_d;
    end
  end
  // rr_q = 1 means the last grant went to a write, so a tied request goes to the read.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    haddr_d   = haddr_q;
    hwdata_d  = hwdata_q;
    rdata_d   = rdata_q;
    hwrite_d  = hwrite_q;
    hsize_d   = hsize_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    arready_o = 1'b0;
    grant_w   = awvalid_i && wvalid_i && !(arvalid_i && rr_q);
    grant_r   = arvalid_i && !grant_w;
    case (state_q)
      S_IDLE: begin
        if (grant_w) begin
          awready_o = 1'b1;
          wready_o  = 1'b1;
          rr_d      = 1'b1;
          haddr_d   = (awaddr_i & ~ADDR_W'(3)) | ADDR_W'(dec_lsb);
          hwdata_d  = wdata_i;
          hwrite_d  = 1'b1;
          hsize_d   = dec_hsize;
          bresp_d   = dec_illegal ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          state_d   = dec_illegal ? S_WRESP : S_WADDR;
        end else if (grant_r) begin
          arready_o = 1'b1;
          rr_d      = 1'b0;
          haddr_d   = araddr_i & ~ADDR_W'(3);
          hwrite_d  = 1'b0;
          hsize_d   = HSIZE_WORD;
          state_d   = S_RADDR;
        end
      end
      S_WADDR: state_d = hready_i ? S_WDATA : S_WADDR;
      S_RADDR: state_d = hready_i ? S_RDATA : S_RADDR;
      S_WDATA: begin
        if (hready_i) begin
          bresp_d = hresp_i ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          state_d = S_WRESP;
        end
      end
      S_RDATA: begin
        if (hready_i) begin
          rresp_d = hresp_i ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          rdata_d = hrdata_i;
          state_d = S_RRESP;
        end
      end
      S_WRESP: state_d = bready_i ? S_IDLE : S_WRESP;
      S_RRESP: state_d = rready_i ? S_IDLE : S_RRESP;
      default: state_d = S_IDLE;
    endcase
  end
  assign htrans_o = (state_q == S_WADDR || state_q == S_RADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bvalid_o = state_q == S_WRESP;
  assign rvalid_o = state_q == S_RRESP;
  assign bresp_o  = bresp_q;
  assign rresp_o  = rresp_q;
  assign rdata_o  = rdata_q;
  assign haddr_o  = haddr_q;
  assign hwdata_o = hwdata_q;
  assign hwrite_o = hwrite_q;
  assign hsize_o  = hsize_q;
  assign hburst_o = HBURST_SINGLE;
  assign hprot_o  = HPROT_DATA_NC;
endmodule

// File: tb/tb_axi_lite_ahb_bridge.sv
// tb_axi_lite_ahb_bridge: directed table-driven and sequence checks of the AXI-Lite to AHB-Lite bridge
module tb_axi_lite_ahb_bridge;
  logic        clk = 1'b0, reset = 1'b0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, hrdata = 0;
  logic [3:0]  wstrb = 0;
  logic        hready = 1, hresp = 0;
  logic        awready, wready, bvalid, arready, rvalid, hwrite;
  logic [1:0]  bresp, rresp, htrans;
  logic [31:0] rdata, haddr, hwdata;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  int checks = 0, failures = 0;

  axi_lite_ahb_bridge dut (
    .clk(clk), .reset(reset),
    .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr),
    .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb),
    .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
    .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
    .haddr_o(haddr), .htrans_o(htrans), .hwrite_o(hwrite), .hsize_o(hsize),
    .hburst_o(hburst), .hprot_o(hprot), .hwdata_o(hwdata),
    .hrdata_i(hrdata), .hready_i(hready), .hresp_i(hresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] exp_haddr;
    logic [2:0]  exp_hsize;
    logic        exp_ill;
  } vec_t;
  vec_t tbl[11];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    tbl[0]  = '{4'b0100, 32'h300, 32'h302, 3'b000, 1'b0};
    tbl[1]  = '{4'b0101, 32'h300, 32'h0,   3'b000, 1'b1};
    tbl[2]  = '{4'b0001, 32'h300, 32'h300, 3'b000, 1'b0};
    tbl[3]  = '{4'b0010, 32'h300, 32'h301, 3'b000, 1'b0};
    tbl[4]  = '{4'b1000, 32'h300, 32'h303, 3'b000, 1'b0};
    tbl[5]  = '{4'b0011, 32'h300, 32'h300, 3'b001, 1'b0};
    tbl[6]  = '{4'b1100, 32'h300, 32'h302, 3'b001, 1'b0};
    tbl[7]  = '{4'b1111, 32'h303, 32'h300, 3'b010, 1'b0};
    tbl[8]  = '{4'b0000, 32'h300, 32'h0,   3'b000, 1'b1};
    tbl[9]  = '{4'b0110, 32'h300, 32'h0,   3'b000, 1'b1};
    tbl[10] = '{4'b0100, 32'h3FF, 32'h3FE, 3'b000, 1'b0};

    repeat (2) tick();
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_htrans", 32'(htrans), 0);
    chk("rst_haddr", haddr, 0);
    chk("rst_hwdata", hwdata, 0);
    chk("rst_hwrite", 32'(hwrite), 0);
    chk("rst_hsize", 32'(hsize), 0);
    chk("rst_bresp", 32'(bresp), 0);
    chk("rst_rresp", 32'(rresp), 0);
    chk("rst_rdata", rdata, 0);
    chk("hburst", 32'(hburst), 0);
    chk("hprot", 32'(hprot), 32'h3);
    reset = 1;
    tick();

    // zero-wait word write
    awvalid = 1; wvalid = 1; awaddr = 32'h100; wdata = 32'hDEADBEEF; wstrb = 4'b1111;
    #1;
    chk("w0_awready", 32'(awready), 1);
    chk("w0_wready", 32'(wready), 1);
    tick();
    awvalid = 0; wvalid = 0;
    #1;
    chk("w1_htrans", 32'(htrans), 32'h2);
    chk("w1_haddr", haddr, 32'h100);
    chk("w1_hsize", 32'(hsize), 32'h2);
    chk("w1_hwrite", 32'(hwrite), 1);
    tick();
    chk("w2_htrans", 32'(htrans), 0);
    chk("w2_hwdata", hwdata, 32'hDEADBEEF);
    chk("w2_bvalid", 32'(bvalid), 0);
    tick();
    chk("w3_bvalid", 32'(bvalid), 1);
    chk("w3_bresp", 32'(bresp), 0);
    bready = 1;
    tick();
    bready = 0;
    chk("w4_bvalid", 32'(bvalid), 0);

    // read with three data-phase wait states
    arvalid = 1; araddr = 32'h204;
    #1;
    chk("r0_arready", 32'(arready), 1);
    tick();
    arvalid = 0;
    #1;
    chk("r1_htrans", 32'(htrans), 32'h2);
    chk("r1_haddr", haddr, 32'h204);
    chk("r1_hwrite", 32'(hwrite), 0);
    chk("r1_hsize", 32'(hsize), 32'h2);
    tick();
    hready = 0;
    tick();
    tick();
    tick();
    hready = 1; hrdata = 32'h12345678;
    #1;
    chk("r5_rvalid", 32'(rvalid), 0);
    tick();
    hrdata = 0;
    chk("r6_rvalid", 32'(rvalid), 1);
    chk("r6_rdata", rdata, 32'h12345678);
    chk("r6_rresp", 32'(rresp), 0);
    rready = 1;
    tick();
    rready = 0;
    chk("r7_rvalid", 32'(rvalid), 0);

    // write with a two-cycle AHB error, then a clean read
    awvalid = 1; wvalid = 1; awaddr = 32'h400; wdata = 32'h55AA55AA; wstrb = 4'b1111;
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    hready = 0; hresp = 1;
    #1;
    chk("e2_htrans", 32'(htrans), 0);
    tick();
    hready = 1;
    #1;
    chk("e3_bvalid", 32'(bvalid), 0);
    chk("e3_hwdata", hwdata, 32'h55AA55AA);
    tick();
    hresp = 0;
    for (int i = 0; i < 2; i++) begin
      chk("e_bvalid", 32'(bvalid), 1);
      chk("e_bresp", 32'(bresp), 32'h2);
      tick();
    end
    bready = 1;
    tick();
    bready = 0;
    arvalid = 1; araddr = 32'h500;
    tick();
    arvalid = 0;
    tick();
    hrdata = 32'hCAFEF00D;
    tick();
    hrdata = 0;
    chk("er_rvalid", 32'(rvalid), 1);
    chk("er_rresp", 32'(rresp), 0);
    chk("er_rdata", rdata, 32'hCAFEF00D);
    rready = 1;
    tick();
    rready = 0;

    // strobe decode table, each entry a full write
    for (int i = 0; i < 11; i++) begin
      awvalid = 1; wvalid = 1; awaddr = tbl[i].addr; wdata = 32'hA0B0C000 + i; wstrb = tbl[i].strb;
      tick();
      awvalid = 0; wvalid = 0;
      #1;
      if (tbl[i].exp_ill) begin
        chk($sformatf("t%0d_htrans", i), 32'(htrans), 0);
        chk($sformatf("t%0d_bvalid", i), 32'(bvalid), 1);
        chk($sformatf("t%0d_bresp", i), 32'(bresp), 32'h2);
      end else begin
        chk($sformatf("t%0d_htrans", i), 32'(htrans), 32'h2);
        chk($sformatf("t%0d_haddr", i), haddr, tbl[i].exp_haddr);
        chk($sformatf("t%0d_hsize", i), 32'(hsize), 32'(tbl[i].exp_hsize));
        tick();
        tick();
        chk($sformatf("t%0d_bvalid", i), 32'(bvalid), 1);
        chk($sformatf("t%0d_bresp", i), 32'(bresp), 0);
      end
      bready = 1;
      tick();
      bready = 0;
    end

    // simultaneous write and read: last grant was a write, so the read goes first
    awvalid = 1; wvalid = 1; awaddr = 32'h600; wdata = 32'h11112222; wstrb = 4'b1111;
    arvalid = 1; araddr = 32'h700;
    #1;
    chk("rr0_arready", 32'(arready), 1);
    chk("rr0_awready", 32'(awready), 0);
    tick();
    arvalid = 0;
    #1;
    chk("rr1_awready", 32'(awready), 0);
    chk("rr1_hwrite", 32'(hwrite), 0);
    chk("rr1_haddr", haddr, 32'h700);
    tick();
    hrdata = 32'hA5A5A5A5;
    tick();
    hrdata = 0;
    chk("rr3_rvalid", 32'(rvalid), 1);
    chk("rr3_rdata", rdata, 32'hA5A5A5A5);
    rready = 1;
    tick();
    rready = 0;
    #1;
    chk("rr4_awready", 32'(awready), 1);
    tick();
    awvalid = 0; wvalid = 0;
    #1;
    chk("rr5_hwrite", 32'(hwrite), 1);
    chk("rr5_haddr", haddr, 32'h600);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("rr_hold_bvalid", 32'(bvalid), 1);
      chk("rr_hold_bresp", 32'(bresp), 0);
      tick();
    end
    bready = 1;
    tick();
    bready = 0;
    chk("rr_bvalid_done", 32'(bvalid), 0);

    // reset during the read data phase drops the transfer
    arvalid = 1; araddr = 32'h800;
    tick();
    arvalid = 0;
    tick();
    hready = 0; hrdata = 32'hFFFF0000;
    #1;
    reset = 0;
    #1;
    chk("ar_htrans", 32'(htrans), 0);
    chk("ar_rvalid", 32'(rvalid), 0);
    tick();
    reset = 1; hready = 1;
    tick();
    tick();
    chk("ar_post_rvalid", 32'(rvalid), 0);
    chk("ar_post_htrans", 32'(htrans), 0);
    chk("ar_post_rdata", rdata, 0);
    hrdata = 0;
    arvalid = 1; araddr = 32'h900;
    #1;
    chk("ar_new_arready", 32'(arready), 1);
    tick();
    arvalid = 0;
    tick();
    hrdata = 32'h0BADF00D;
    tick();
    hrdata = 0;
    chk("ar_new_rvalid", 32'(rvalid), 1);
    chk("ar_new_rdata", rdata, 32'h0BADF00D);
    chk("ar_new_rresp", 32'(rresp), 0);
    rready = 1;
    tick();
    rready = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
